// File: rtl/bkg_pkg.sv
// Shared constants for the background tile fetch path and its collision-logic users.
package bkg_pkg;

  localparam int unsigned TILE_SHIFT = 5;
  localparam int unsigned MAP_W      = 20;
  localparam int unsigned MAP_H      = 15;
  localparam int unsigned ADDR_W     = 9;
  localparam int unsigned CODE_W     = 3;
  localparam int unsigned PIX_W      = 10;
  localparam int unsigned COL_W      = PIX_W - TILE_SHIFT;
  localparam int unsigned MAP_N      = MAP_W * MAP_H;

  localparam logic [CODE_W-1:0] TILE_FLOOR = CODE_W'(0);
  localparam logic [CODE_W-1:0] TILE_WALL  = CODE_W'(6);

endpackage

// File: rtl/bkg_tile_addr.sv
// Combinational pixel-to-tile mapping: tile index, in-map flag and offset inside the tile.
module bkg_tile_addr
  import bkg_pkg::*;
(
  input  logic [PIX_W-1:0]      i_x,
  input  logic [PIX_W-1:0]      i_y,
  input  logic                  i_valid,
  output logic [ADDR_W-1:0]     o_addr,
  output logic                  o_in_map,
  output logic [TILE_SHIFT-1:0] o_px,
  output logic [TILE_SHIFT-1:0] o_py
);

  logic [COL_W-1:0]  w_col;
  logic [COL_W-1:0]  w_row;
  logic [ADDR_W-1:0] w_col_a;
  logic [ADDR_W-1:0] w_row_a;
  logic [ADDR_W-1:0] w_addr_raw;

  assign w_col    = i_x[PIX_W-1:TILE_SHIFT];
  assign w_row    = i_y[PIX_W-1:TILE_SHIFT];
  assign w_col_a  = ADDR_W'(w_col);
  assign w_row_a  = ADDR_W'(w_row);
  assign o_in_map = i_valid && (32'(w_col) < MAP_W) && (32'(w_row) < MAP_H);

  // row*20 as shift-add; only meaningful while in the map
  assign w_addr_raw = (w_row_a << 4) + (w_row_a << 2) + w_col_a;
  assign o_addr     = o_in_map ? w_addr_raw : '0;

  assign o_px = i_x[TILE_SHIFT-1:0];
  assign o_py = i_y[TILE_SHIFT-1:0];

endmodule

// File: rtl/bkg_tile_fetch.sv
// Two-stage background tile fetch: address stage, ROM code register, aligned syncs.
// Optional destroyed-tile mask enabled by defining BKG_DESTROY_EN.
module bkg_tile_fetch
  import bkg_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PIX_W-1:0]      i_pix_x,
  input  logic [PIX_W-1:0]      i_pix_y,
  input  logic                  i_pix_valid,
  input  logic                  i_hsync,
  input  logic                  i_vsync,
  output logic [ADDR_W-1:0]     o_rom_addr,
  input  logic [CODE_W-1:0]     i_rom_q,
  input  logic                  i_map_reset,
  input  logic                  i_clr_req,
  input  logic [ADDR_W-1:0]     i_clr_tile,
  output logic                  o_clr_ack,
  output logic [CODE_W-1:0]     o_tile_code,
  output logic [TILE_SHIFT-1:0] o_tile_px,
  output logic [TILE_SHIFT-1:0] o_tile_py,
  output logic                  o_out_valid,
  output logic                  o_hsync,
  output logic                  o_vsync
);

  logic [ADDR_W-1:0]     w_addr;
  logic                  w_in_map;
  logic [TILE_SHIFT-1:0] w_px;
  logic [TILE_SHIFT-1:0] w_py;
  logic                  w_destroyed;
  logic [CODE_W-1:0]     w_code_d;

  logic [ADDR_W-1:0]     r_s1_addr;
  logic                  r_s1_in_map;
  logic [TILE_SHIFT-1:0] r_s1_px;
  logic [TILE_SHIFT-1:0] r_s1_py;
  logic                  r_s1_hs;
  logic                  r_s1_vs;

  logic [CODE_W-1:0]     r_code;
  logic                  r_valid;
  logic [TILE_SHIFT-1:0] r_px;
  logic [TILE_SHIFT-1:0] r_py;
  logic                  r_hs;
  logic                  r_vs;
  logic                  r_clr_ack;

  bkg_tile_addr u_addr (
    .i_x      (i_pix_x),
    .i_y      (i_pix_y),
    .i_valid  (i_pix_valid),
    .o_addr   (w_addr),
    .o_in_map (w_in_map),
    .o_px     (w_px),
    .o_py     (w_py)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_addr   <= '0;
      r_s1_in_map <= 1'b0;
      r_s1_px     <= '0;
      r_s1_py     <= '0;
      r_s1_hs     <= 1'b0;
      r_s1_vs     <= 1'b0;
      r_code      <= '0;
      r_valid     <= 1'b0;
      r_px        <= '0;
      r_py        <= '0;
      r_hs        <= 1'b0;
      r_vs        <= 1'b0;
      r_clr_ack   <= 1'b0;
    end else begin
      r_s1_addr   <= w_addr;
      r_s1_in_map <= w_in_map;
      r_s1_px     <= w_px;
      r_s1_py     <= w_py;
      r_s1_hs     <= i_hsync;
      r_s1_vs     <= i_vsync;
      r_code      <= w_code_d;
      r_valid     <= r_s1_in_map;
      r_px        <= r_s1_px;
      r_py        <= r_s1_py;
      r_hs        <= r_s1_hs;
      r_vs        <= r_s1_vs;
      r_clr_ack   <= i_clr_req;
    end
  end

`ifdef BKG_DESTROY_EN
  logic [MAP_N-1:0] r_mask;

  // map_reset takes priority over a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask <= '0;
    end else if (i_map_reset) begin
      r_mask <= '0;
    end else if (i_clr_req && (32'(i_clr_tile) < MAP_N)) begin
      r_mask[i_clr_tile] <= 1'b1;
    end
  end

  assign w_destroyed = r_mask[r_s1_addr];
`else
  logic w_unused_cfg;

  assign w_unused_cfg = ^{i_map_reset, i_clr_tile};
  assign w_destroyed  = 1'b0;
`endif

  assign w_code_d = (r_s1_in_map && !w_destroyed) ? i_rom_q : TILE_FLOOR;

  assign o_rom_addr  = r_s1_addr;
  assign o_tile_code = r_code;
  assign o_out_valid = r_valid;
  assign o_tile_px   = r_px;
  assign o_tile_py   = r_py;
  assign o_hsync     = r_hs;
  assign o_vsync     = r_vs;
  assign o_clr_ack   = r_clr_ack;

endmodule

// File: tb/tb_bkg_tile_fetch.sv
// Randomized and directed bench for bkg_tile_fetch against a pixel-level reference model.
module tb_bkg_tile_fetch;

  logic       clk;
  logic       rst_n;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       pix_valid;
  logic       hsync_in;
  logic       vsync_in;
  logic [8:0] rom_addr;
  logic [2:0] rom_q;
  logic       map_reset;
  logic       clr_req;
  logic [8:0] clr_tile;
  logic       clr_ack;
  logic [2:0] tile_code;
  logic [4:0] tile_px;
  logic [4:0] tile_py;
  logic       out_valid;
  logic       hsync_out;
  logic       vsync_out;

  bkg_tile_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_pix_x     (pix_x),
    .i_pix_y     (pix_y),
    .i_pix_valid (pix_valid),
    .i_hsync     (hsync_in),
    .i_vsync     (vsync_in),
    .o_rom_addr  (rom_addr),
    .i_rom_q     (rom_q),
    .i_map_reset (map_reset),
    .i_clr_req   (clr_req),
    .i_clr_tile  (clr_tile),
    .o_clr_ack   (clr_ack),
    .o_tile_code (tile_code),
    .o_tile_px   (tile_px),
    .o_tile_py   (tile_py),
    .o_out_valid (out_valid),
    .o_hsync     (hsync_out),
    .o_vsync     (vsync_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rom_mem [300];

  always_comb begin
    rom_q = 3'd0;
    if (int'(rom_addr) < 300) rom_q = rom_mem[rom_addr];
  end

  typedef struct {
    logic [8:0] addr;
    logic       valid;
    logic [2:0] code;
    logic [4:0] px;
    logic [4:0] py;
    logic       hs;
    logic       vs;
  } rec_t;

  bit   tb_mask [300];
  rec_t h1, h2, zero_rec;
  logic prev_req;
  logic rst_next;
  int   n_pass;
  int   n_total;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic rec_t model(input int x, input int y, input bit v, input bit hs,
                                 input bit vs);
    rec_t r;
    int col, row, idx;
    col = x / 32;
    row = y / 32;
    r.valid = v && col < 20 && row < 15;
    idx     = row * 20 + col;
    r.addr  = r.valid ? 9'(idx) : 9'd0;
    r.code  = (r.valid && !tb_mask[idx]) ? rom_mem[idx] : 3'd0;
    r.px    = 5'(x % 32);
    r.py    = 5'(y % 32);
    r.hs    = hs;
    r.vs    = vs;
    return r;
  endfunction

  task automatic clear_model();
    h1 = zero_rec;
    h2 = zero_rec;
    prev_req = 1'b0;
    for (int i = 0; i < 300; i++) tb_mask[i] = 1'b0;
  endtask

  // Check outputs of pixels applied one and two steps ago, then apply a new pixel.
  task automatic step(input int x, input int y, input bit v, input bit hs, input bit vs,
                      input bit req, input int tile, input bit mr);
    @(negedge clk);
    chk("rom_addr", int'(rom_addr), int'(h1.addr));
    chk("out_valid", int'(out_valid), int'(h2.valid));
    chk("tile_code", int'(tile_code), int'(h2.code));
    chk("tile_px", int'(tile_px), int'(h2.px));
    chk("tile_py", int'(tile_py), int'(h2.py));
    chk("hsync_out", int'(hsync_out), int'(h2.hs));
    chk("vsync_out", int'(vsync_out), int'(h2.vs));
    chk("clr_ack", int'(clr_ack), int'(prev_req));
    rst_n     = rst_next;
    pix_x     = 10'(x);
    pix_y     = 10'(y);
    pix_valid = v;
    hsync_in  = hs;
    vsync_in  = vs;
    clr_req   = req;
    clr_tile  = 9'(tile);
    map_reset = mr;
    h2 = h1;
    if (rst_n) begin
`ifdef BKG_DESTROY_EN
      if (mr) begin
        for (int i = 0; i < 300; i++) tb_mask[i] = 1'b0;
      end else if (req && tile < 300) begin
        tb_mask[tile] = 1'b1;
      end
`endif
      prev_req = req;
      h1 = model(x, y, v, hs, vs);
    end else begin
      prev_req = 1'b0;
      h1 = zero_rec;
    end
  endtask

  task automatic pix(input int x, input int y);
    step(x, y, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic rand_step();
    step($urandom_range(0, 700), $urandom_range(0, 520), $urandom_range(0, 3) != 0,
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
         $urandom_range(0, 330), $urandom_range(0, 40) == 0);
  endtask

  initial begin
    rst_n = 1'b0;
    rst_next = 1'b0;
    pix_x = '0; pix_y = '0; pix_valid = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    clr_req = 1'b0; clr_tile = '0; map_reset = 1'b0;
    n_pass = 0;
    n_total = 0;
    zero_rec = '{addr: 9'd0, valid: 1'b0, code: 3'd0, px: 5'd0, py: 5'd0, hs: 1'b0, vs: 1'b0};
    for (int i = 0; i < 300; i++) rom_mem[i] = 3'($urandom_range(1, 7));
    rom_mem[1] = 3'd6;
    rom_mem[7] = 3'd6;
    clear_model();

    // reset held while pixels stream, then release
    for (int i = 0; i < 4; i++) step(i * 40, 20, 1'b1, 1'b1, 1'b1, 1'b1, 3, 1'b0);
    rst_next = 1'b1;
    for (int i = 0; i < 4; i++) pix(100 + i, 33);

    // tile-row-major sweep, one random pixel per tile
    for (int r = 0; r < 15; r++) begin
      for (int c = 0; c < 20; c++) begin
        step(c * 32 + $urandom_range(0, 31), r * 32 + $urandom_range(0, 31), 1'b1,
             c == 0, r == 0 && c == 0, 1'b0, 0, 1'b0);
      end
    end

    // boundaries and invalid pixels
    pix(639, 479);
    pix(0, 0);
    step(640, 10, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    step(10, 480, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    step(100, 100, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    step(1023, 1023, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    pix(639, 0);
    pix(0, 479);

`ifdef BKG_DESTROY_EN
    // clear wall tile 1, then fetch it
    pix(32, 0);
    step(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0);
    pix(32, 0);
    pix(33, 5);
    pix(0, 0);
    // map_reset wins over same-cycle clear of tile 7
    step(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 7, 1'b1);
    pix(7 * 32, 0);
    pix(32, 0);
    step(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 300, 1'b0);
    pix(7 * 32, 0);
    pix(0, 0);
`else
    // clears still acknowledged without the mask
    step(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0);
    step(32, 0, 1'b1, 1'b0, 1'b0, 1'b1, 7, 1'b1);
    pix(7 * 32, 0);
    pix(0, 0);
`endif

    for (int i = 0; i < 1500; i++) rand_step();

    // async reset pulse mid-line
    for (int i = 0; i < 3; i++) step(64 + i, 64, 1'b1, 1'b1, 1'b0, 1'b1, 2, 1'b0);
    #2;
    rst_n = 1'b0;
    rst_next = 1'b0;
    #1;
    chk("async_rst_valid", int'(out_valid), 0);
    chk("async_rst_code", int'(tile_code), 0);
    chk("async_rst_addr", int'(rom_addr), 0);
    chk("async_rst_hsync", int'(hsync_out), 0);
    chk("async_rst_ack", int'(clr_ack), 0);
    chk("async_rst_px", int'(tile_px), 0);
    clear_model();
    for (int i = 0; i < 2; i++) step(200, 200, 1'b1, 1'b1, 1'b1, 1'b1, 4, 1'b0);
    rst_next = 1'b1;
    for (int i = 0; i < 400; i++) rand_step();
    for (int i = 0; i < 3; i++) step(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
